// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : cpu_sequencer_if                                              |
// | Description : Instruction-fetch, decoder and write-strobe bundle between    |
// |               the sequencer and the rest of the 8-puzzle datapath.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
interface cpu_sequencer_if #(
    parameter int PC_W = 6,
    parameter int OP_W = 16
);
    logic            imem_rd;
    logic [PC_W-1:0] imem_addr;
    logic [OP_W-1:0] imem_data;
    logic [OP_W-1:0] op;
    logic [PC_W-1:0] dec_pc_in;
    logic            dec_pc_we;
    logic            dec_reg_we;
    logic            dec_mem_we;
    logic            reg_we;
    logic            mem_we;

    modport master (
        output imem_rd, imem_addr, op, reg_we, mem_we,
        input  imem_data, dec_pc_in, dec_pc_we, dec_reg_we, dec_mem_we
    );

    modport slave (
        input  imem_rd, imem_addr, op, reg_we, mem_we,
        output imem_data, dec_pc_in, dec_pc_we, dec_reg_we, dec_mem_we
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : cpu_sequencer                                                 |
// | Description : Multi-cycle FETCH/LOAD/EXEC control sequencer with PC,        |
// |               single-cycle commit strobes and start/halt/done control.      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module cpu_sequencer #(
    parameter int              PC_W    = 6,
    parameter int              OP_W    = 16,
    parameter logic [OP_W-1:0] HALT_OP = 16'hFFFF
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              start,
    input  wire              halt_req,
    cpu_sequencer_if.master  bus,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             done,
    output logic [15:0]      instr_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [OP_W-1:0] r_op;
    logic [15:0]     r_cnt;
    logic            r_halt;

    logic            w_commit;
    logic            w_halt_now;

    // A halt request arriving during EXEC itself still ends the run after this commit.
    assign w_halt_now = r_halt | halt_req;
    assign w_commit   = (r_state == S_EXEC) && (r_op != HALT_OP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_cnt   <= '0;
                        r_halt  <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (halt_req) begin
                        r_halt <= 1'b1;
                    end
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (halt_req) begin
                        r_halt <= 1'b1;
                    end
                    r_op    <= bus.imem_data;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_halt <= w_halt_now;
                    if (r_op == HALT_OP) begin
                        r_state <= S_STOP;
                    end else begin
                        r_pc <= bus.dec_pc_we ? bus.dec_pc_in : r_pc + PC_W'(1);
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                        r_state <= w_halt_now ? S_STOP : S_FETCH;
                    end
                end
                S_STOP: begin
                    r_halt  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the registered state, so reset kills them at once.
    assign bus.imem_rd   = (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.op        = r_op;
    assign bus.reg_we    = w_commit & bus.dec_reg_we;
    assign bus.mem_we    = w_commit & bus.dec_mem_we;

    assign pc        = r_pc;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_STOP);
    assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_cpu_sequencer                                              |
// | Description : Self-checking bench: directed and random programs against an  |
// |               instruction-level reference model.                            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_cpu_sequencer;
    localparam int          PC_W    = 6;
    localparam int          OP_W    = 16;
    localparam logic [15:0] HALT_OP = 16'hFFFF;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            halt_req;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            done;
    logic [15:0]     instr_cnt;

    logic [15:0] rom [64];

    int n_cmp = 0;
    int n_bad = 0;

    cpu_sequencer_if #(.PC_W(PC_W), .OP_W(OP_W)) bus ();

    cpu_sequencer #(
        .PC_W    (PC_W),
        .OP_W    (OP_W),
        .HALT_OP (HALT_OP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .halt_req  (halt_req),
        .bus       (bus),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM and a toy decoder: bit0 reg write, bit1 mem write,
    // bit2 branch, bits 8:3 branch target.
    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_data <= rom[bus.imem_addr];
    end
    assign bus.dec_reg_we = bus.op[0];
    assign bus.dec_mem_we = bus.op[1];
    assign bus.dec_pc_we  = bus.op[2];
    assign bus.dec_pc_in  = bus.op[8:3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input logic [15:0] val);
        for (int k = 0; k < 64; k++) rom[k] = val;
    endtask

    // Runs one program from PC 0; halt_req is raised during LOAD of instruction halt_at.
    task automatic run_prog(input int halt_at, input int max_instr, input bit halt_with_start);
        logic [PC_W-1:0] mpc;
        int              cnt;
        bit              pend;
        bit              stopped;
        logic [15:0]     w;
        mpc     = '0;
        cnt     = 0;
        pend    = 1'b0;
        stopped = 1'b0;
        start    = 1'b1;
        halt_req = halt_with_start;
        tick();
        start    = 1'b0;
        halt_req = 1'b0;
        for (int i = 0; i < max_instr && !stopped; i++) begin
            check("fetch_rd", bus.imem_rd, 1);
            check("fetch_addr", bus.imem_addr, mpc);
            check("fetch_pc", pc, mpc);
            check("fetch_we", {bus.reg_we, bus.mem_we}, 0);
            check("fetch_busy", busy, 1);
            tick();
            if (i == halt_at) halt_req = 1'b1;
            start = $urandom_range(0, 1);
            check("load_rd", bus.imem_rd, 0);
            check("load_we", {bus.reg_we, bus.mem_we}, 0);
            tick();
            halt_req = 1'b0;
            start    = 1'b0;
            if (i == halt_at) pend = 1'b1;
            w = rom[mpc];
            check("exec_op", bus.op, w);
            check("exec_rd", bus.imem_rd, 0);
            if (w == HALT_OP) begin
                check("halt_we", {bus.reg_we, bus.mem_we}, 0);
                stopped = 1'b1;
            end else begin
                check("exec_reg_we", bus.reg_we, w[0]);
                check("exec_mem_we", bus.mem_we, w[1]);
                mpc = w[2] ? w[8:3] : mpc + 6'd1;
                if (cnt < 65535) cnt++;
                stopped = pend;
            end
            tick();
        end
        check("run_stopped", stopped, 1);
        check("stop_done", done, 1);
        check("stop_busy", busy, 1);
        check("stop_pc", pc, mpc);
        check("stop_cnt", instr_cnt, cnt);
        check("stop_sig", {bus.imem_rd, bus.reg_we, bus.mem_we}, 0);
        tick();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_rd", bus.imem_rd, 0);
        check("idle_op", bus.op, (w == HALT_OP) ? HALT_OP : w);
        tick();
        check("idle_rd2", bus.imem_rd, 0);
        check("idle_cnt", instr_cnt, cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        halt_req = 1'b0;
        fill_rom(16'h0000);
        tick();
        tick();
        check("rst_pc", pc, 0);
        check("rst_op", bus.op, 0);
        check("rst_cnt", instr_cnt, 0);
        check("rst_ctl", {busy, done, bus.imem_rd, bus.reg_we, bus.mem_we}, 0);
        rst = 1'b0;
        tick();

        // INC, COPY, HALT; halt_req together with start must be ignored
        fill_rom(16'h0000);
        rom[0] = 16'h0001;
        rom[1] = 16'h0001;
        rom[2] = HALT_OP;
        run_prog(-1, 8, 1'b1);

        // jump to 0x20 at address 0
        fill_rom(16'h0000);
        rom[0]    = (16'h20 << 3) | 16'h4;
        rom[6'h20] = HALT_OP;
        run_prog(-1, 4, 1'b0);

        // store at address 5
        fill_rom(16'h0000);
        rom[5] = 16'h0002;
        rom[6] = HALT_OP;
        run_prog(-1, 10, 1'b0);

        // halt during LOAD of instruction 3
        fill_rom(16'h0000);
        run_prog(3, 10, 1'b0);

        // wrap from 63 to 0
        fill_rom(16'h0000);
        rom[0]  = (16'd63 << 3) | 16'h4;
        run_prog(2, 6, 1'b0);

        // reset in EXEC of a store, then a clean restart
        fill_rom(16'h0000);
        rom[0] = 16'h0002;
        rom[1] = HALT_OP;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_mem_we", bus.mem_we, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_pc2", pc, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_cnt2", instr_cnt, 0);
        run_prog(-1, 4, 1'b0);

        // random programs
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 64; k++) begin
                rom[k] = ($urandom_range(0, 15) == 0) ? HALT_OP : 16'($urandom & 32'h01FF);
            end
            run_prog($urandom_range(0, 15), 20, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
